// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and a load-use hazard stall.
// Bubbles are injected on reset, flush, hazard or an invalid ID slot.
module id_ex_stage #(
  parameter logic [4:0] BUBBLE_OP = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_alu_op_i,
  input  logic        id_src_a_sel_i,
  input  logic        id_src_b_sel_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_reg_we_i,
  input  logic        id_mem_re_i,
  input  logic        id_mem_we_i,
  input  logic        flush_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_reg_we_i,
  input  logic [31:0] mem_fwd_data_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_reg_we_i,
  input  logic [31:0] wb_data_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_imm_o,
  output logic [31:0] ex_a_o,
  output logic [31:0] ex_b_o,
  output logic [31:0] ex_store_data_o,
  output logic [4:0]  ex_alu_op_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_reg_we_o,
  output logic        ex_mem_re_o,
  output logic        ex_mem_we_o,
  output logic        stall_o
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic        r_use_rs1;
  logic        r_use_rs2;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [4:0]  r_alu_op;
  logic        r_src_a_sel;
  logic        r_src_b_sel;
  logic [4:0]  r_rd;
  logic        r_reg_we;
  logic        r_mem_re;
  logic        r_mem_we;

  logic        w_haz;
  logic        w_bubble;
  logic        w_wt_rs1;
  logic        w_wt_rs2;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;

  assign w_haz = r_valid && r_mem_re && (r_rd != '0) && id_valid_i &&
                 ((id_use_rs1_i && (id_rs1_i == r_rd)) ||
                  (id_use_rs2_i && (id_rs2_i == r_rd)));

  assign stall_o  = w_haz && !flush_i;
  assign w_bubble = rst || flush_i || w_haz || !id_valid_i;

  // The WB write lands in the register file on the same edge, so capture it here instead.
  assign w_wt_rs1 = id_use_rs1_i && wb_reg_we_i && (wb_rd_i != '0) && (wb_rd_i == id_rs1_i);
  assign w_wt_rs2 = id_use_rs2_i && wb_reg_we_i && (wb_rd_i != '0) && (wb_rd_i == id_rs2_i);

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_use_rs1   <= 1'b0;
      r_use_rs2   <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_alu_op    <= BUBBLE_OP;
      r_src_a_sel <= 1'b0;
      r_src_b_sel <= 1'b0;
      r_rd        <= '0;
      r_reg_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_valid     <= 1'b1;
      r_pc        <= id_pc_i;
      r_imm       <= id_imm_i;
      r_rs1       <= id_rs1_i;
      r_rs2       <= id_rs2_i;
      r_use_rs1   <= id_use_rs1_i;
      r_use_rs2   <= id_use_rs2_i;
      r_rs1_data  <= w_wt_rs1 ? wb_data_i : id_rs1_data_i;
      r_rs2_data  <= w_wt_rs2 ? wb_data_i : id_rs2_data_i;
      r_alu_op    <= id_alu_op_i;
      r_src_a_sel <= id_src_a_sel_i;
      r_src_b_sel <= id_src_b_sel_i;
      r_rd        <= id_rd_i;
      r_reg_we    <= id_reg_we_i;
      r_mem_re    <= id_mem_re_i;
      r_mem_we    <= id_mem_we_i;
    end
  end

  // EX/MEM beats MEM/WB; x0 and unused sources fall through to the latched value.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (r_use_rs1 && (r_rs1 != '0)) begin
      if (mem_reg_we_i && (mem_rd_i == r_rs1))
        w_fwd_rs1 = mem_fwd_data_i;
      else if (wb_reg_we_i && (wb_rd_i == r_rs1))
        w_fwd_rs1 = wb_data_i;
    end
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (r_use_rs2 && (r_rs2 != '0)) begin
      if (mem_reg_we_i && (mem_rd_i == r_rs2))
        w_fwd_rs2 = mem_fwd_data_i;
      else if (wb_reg_we_i && (wb_rd_i == r_rs2))
        w_fwd_rs2 = wb_data_i;
    end
  end

  assign ex_valid_o      = r_valid;
  assign ex_pc_o         = r_pc;
  assign ex_imm_o        = r_imm;
  assign ex_a_o          = r_src_a_sel ? r_pc : w_fwd_rs1;
  assign ex_b_o          = r_src_b_sel ? r_imm : w_fwd_rs2;
  assign ex_store_data_o = w_fwd_rs2;
  assign ex_alu_op_o     = r_valid ? r_alu_op : BUBBLE_OP;
  assign ex_rd_o         = r_rd;
  assign ex_reg_we_o     = r_valid && r_reg_we;
  assign ex_mem_re_o     = r_valid && r_mem_re;
  assign ex_mem_we_o     = r_valid && r_mem_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-stage snapshots are queued when stimulus
// is driven and compared when the corresponding output is observable.
module tb_id_ex_stage;

  localparam logic [4:0] BUBBLE = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_OR  = 5'd2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        id_use_rs1_i, id_use_rs2_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_alu_op_i;
  logic        id_src_a_sel_i, id_src_b_sel_i;
  logic [4:0]  id_rd_i;
  logic        id_reg_we_i, id_mem_re_i, id_mem_we_i;
  logic        flush_i;
  logic [4:0]  mem_rd_i;
  logic        mem_reg_we_i;
  logic [31:0] mem_fwd_data_i;
  logic [4:0]  wb_rd_i;
  logic        wb_reg_we_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o, ex_imm_o, ex_a_o, ex_b_o, ex_store_data_o;
  logic [4:0]  ex_alu_op_o, ex_rd_o;
  logic        ex_reg_we_o, ex_mem_re_o, ex_mem_we_o, stall_o;

  exp_t sb[$];
  exp_t e;
  exp_t act;
  int   n_vec = 0;
  int   n_err = 0;

  id_ex_stage #(.BUBBLE_OP(BUBBLE)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_alu_op_i(id_alu_op_i),
    .id_src_a_sel_i(id_src_a_sel_i), .id_src_b_sel_i(id_src_b_sel_i),
    .id_rd_i(id_rd_i), .id_reg_we_i(id_reg_we_i),
    .id_mem_re_i(id_mem_re_i), .id_mem_we_i(id_mem_we_i),
    .flush_i(flush_i),
    .mem_rd_i(mem_rd_i), .mem_reg_we_i(mem_reg_we_i), .mem_fwd_data_i(mem_fwd_data_i),
    .wb_rd_i(wb_rd_i), .wb_reg_we_i(wb_reg_we_i), .wb_data_i(wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
    .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_store_data_o(ex_store_data_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_rd_o(ex_rd_o),
    .ex_reg_we_o(ex_reg_we_o), .ex_mem_re_o(ex_mem_re_o), .ex_mem_we_o(ex_mem_we_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired sim_time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  always_comb act = '{ex_valid_o, ex_alu_op_o, ex_reg_we_o, ex_mem_re_o, ex_mem_we_o, ex_a_o, ex_b_o};

  task automatic idle();
    rst = 1'b0; flush_i = 1'b0;
    id_valid_i = 1'b0; id_pc_i = '0; id_rs1_i = '0; id_rs2_i = '0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; id_rs1_data_i = '0; id_rs2_data_i = '0;
    id_imm_i = '0; id_alu_op_i = '0; id_src_a_sel_i = 1'b0; id_src_b_sel_i = 1'b0;
    id_rd_i = '0; id_reg_we_i = 1'b0; id_mem_re_i = 1'b0; id_mem_we_i = 1'b0;
    mem_rd_i = '0; mem_reg_we_i = 1'b0; mem_fwd_data_i = '0;
    wb_rd_i = '0; wb_reg_we_i = 1'b0; wb_data_i = '0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    id_valid_i = 1'b1; id_rs1_i = 5'd1; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'h1234;
    id_alu_op_i = OP_ADD; id_rd_i = 5'd3; id_reg_we_i = 1'b1; id_mem_re_i = 1'b1; id_mem_we_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, BUBBLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
      edge1();
      e = sb.pop_front();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, act, e);
      end
      n_vec++;
      if (stall_o !== 1'b0 || ex_rd_o !== 5'd0 || ex_pc_o !== 32'h0) begin
        n_err++;
        $display("FAIL reset_misc[%0d] stall=%b rd=%0d pc=%h exp 0/0/0", i, stall_o, ex_rd_o, ex_pc_o);
      end
    end
  endtask

  task automatic test_pass_through();
    idle();
    id_valid_i = 1'b1; id_pc_i = 32'h100;
    id_rs1_i = 5'd1; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'd5;
    id_rs2_i = 5'd2; id_use_rs2_i = 1'b1; id_rs2_data_i = 32'd7;
    id_alu_op_i = OP_ADD; id_rd_i = 5'd6; id_reg_we_i = 1'b1; id_imm_i = 32'h99;
    sb.push_back('{1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7});
    edge1();
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL pass_through got=%h exp=%h", act, e);
    end
    n_vec++;
    if (ex_pc_o !== 32'h100 || ex_rd_o !== 5'd6 || ex_store_data_o !== 32'd7 || ex_imm_o !== 32'h99) begin
      n_err++;
      $display("FAIL pass_misc pc=%h rd=%0d sd=%h imm=%h exp 100/6/7/99", ex_pc_o, ex_rd_o, ex_store_data_o, ex_imm_o);
    end
  endtask

  task automatic test_forward_priority();
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd3; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'h33;
    id_src_b_sel_i = 1'b1; id_imm_i = 32'h44; id_alu_op_i = OP_OR; id_rd_i = 5'd10; id_reg_we_i = 1'b1;
    edge1();
    mem_rd_i = 5'd3; mem_reg_we_i = 1'b1; mem_fwd_data_i = 32'h11;
    wb_rd_i = 5'd3; wb_reg_we_i = 1'b1; wb_data_i = 32'h22;
    sb.push_back('{1'b1, OP_OR, 1'b1, 1'b0, 1'b0, 32'h11, 32'h44});
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL fwd_mem got=%h exp=%h", act, e); end
    mem_reg_we_i = 1'b0;
    sb.push_back('{1'b1, OP_OR, 1'b1, 1'b0, 1'b0, 32'h22, 32'h44});
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL fwd_wb got=%h exp=%h", act, e); end
    wb_reg_we_i = 1'b0;
    sb.push_back('{1'b1, OP_OR, 1'b1, 1'b0, 1'b0, 32'h33, 32'h44});
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL fwd_none got=%h exp=%h", act, e); end
    // x0 source: matching x0 destinations must not forward
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'h55;
    id_rs2_i = 5'd0; id_use_rs2_i = 1'b1; id_rs2_data_i = 32'h0; id_alu_op_i = OP_ADD;
    edge1();
    mem_rd_i = 5'd0; mem_reg_we_i = 1'b1; mem_fwd_data_i = 32'h11;
    wb_rd_i = 5'd0; wb_reg_we_i = 1'b1; wb_data_i = 32'h22;
    sb.push_back('{1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0});
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL fwd_x0 got=%h exp=%h", act, e); end
    // unused source: index match ignored
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd3; id_use_rs1_i = 1'b0; id_rs1_data_i = 32'h66; id_alu_op_i = OP_ADD;
    edge1();
    mem_rd_i = 5'd3; mem_reg_we_i = 1'b1; mem_fwd_data_i = 32'h11;
    sb.push_back('{1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'h66, 32'h0});
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL fwd_unused got=%h exp=%h", act, e); end
  endtask

  task automatic test_load_use();
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd1; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'h1000;
    id_src_b_sel_i = 1'b1; id_imm_i = 32'd4; id_alu_op_i = OP_ADD;
    id_rd_i = 5'd5; id_reg_we_i = 1'b1; id_mem_re_i = 1'b1;
    sb.push_back('{1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, 32'h1000, 32'd4});
    edge1();
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL lu_load got=%h exp=%h", act, e); end
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd1; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'd9;
    id_rs2_i = 5'd5; id_use_rs2_i = 1'b1; id_rs2_data_i = 32'h0;
    id_alu_op_i = OP_ADD; id_rd_i = 5'd7; id_reg_we_i = 1'b1;
    #1;
    n_vec++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
    sb.push_back('{1'b0, BUBBLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    edge1();
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL lu_bubble got=%h exp=%h", act, e); end
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_release got=%b exp=0", stall_o); end
    wb_rd_i = 5'd5; wb_reg_we_i = 1'b1; wb_data_i = 32'hBEEF;
    sb.push_back('{1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 32'd9, 32'hBEEF});
    edge1();
    wb_reg_we_i = 1'b0;
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL lu_add got=%h exp=%h", act, e); end
    n_vec++;
    if (ex_store_data_o !== 32'hBEEF) begin
      n_err++; $display("FAIL lu_store_data got=%h exp=0000beef", ex_store_data_o);
    end
  endtask

  task automatic test_flush_hazard();
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd1; id_use_rs1_i = 1'b1; id_alu_op_i = OP_ADD;
    id_rd_i = 5'd8; id_reg_we_i = 1'b1; id_mem_re_i = 1'b1;
    edge1();
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd8; id_use_rs1_i = 1'b1; id_alu_op_i = OP_OR;
    id_rd_i = 5'd9; id_reg_we_i = 1'b1; id_mem_we_i = 1'b1;
    #1;
    n_vec++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL fh_haz_only got=%b exp=1", stall_o); end
    flush_i = 1'b1;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL fh_stall got=%b exp=0", stall_o); end
    sb.push_back('{1'b0, BUBBLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    edge1();
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL fh_bubble got=%h exp=%h", act, e); end
  endtask

  task automatic test_writethrough();
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd4; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'h0; id_alu_op_i = OP_ADD;
    wb_rd_i = 5'd4; wb_reg_we_i = 1'b1; wb_data_i = 32'hDEAD;
    sb.push_back('{1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'hDEAD, 32'h0});
    edge1();
    wb_reg_we_i = 1'b0; wb_data_i = 32'h0;
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL wt_rs1 got=%h exp=%h", act, e); end
    // x0 destination must not write through
    idle();
    id_valid_i = 1'b1; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1; id_rs1_data_i = 32'h7; id_alu_op_i = OP_ADD;
    wb_rd_i = 5'd0; wb_reg_we_i = 1'b1; wb_data_i = 32'hDEAD;
    sb.push_back('{1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, 32'h7, 32'h0});
    edge1();
    wb_reg_we_i = 1'b0;
    #1;
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL wt_x0 got=%h exp=%h", act, e); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    id_valid_i = 1'b1; id_alu_op_i = OP_ADD; id_rd_i = 5'd9; id_reg_we_i = 1'b1; id_mem_re_i = 1'b1;
    edge1();
    idle();
    id_valid_i = 1'b1; id_rs2_i = 5'd9; id_use_rs2_i = 1'b1; id_rs2_data_i = 32'h77;
    id_alu_op_i = OP_OR; id_rd_i = 5'd11; id_reg_we_i = 1'b1;
    rst = 1'b1;
    sb.push_back('{1'b0, BUBBLE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    edge1();
    e = sb.pop_front();
    n_vec++;
    if (act !== e || stall_o !== 1'b0) begin
      n_err++; $display("FAIL rms_reset got=%h stall=%b exp=%h stall=0", act, stall_o, e);
    end
    rst = 1'b0;
    sb.push_back('{1'b1, OP_OR, 1'b1, 1'b0, 1'b0, 32'h0, 32'h77});
    edge1();
    e = sb.pop_front();
    n_vec++;
    if (act !== e) begin n_err++; $display("FAIL rms_accept got=%h exp=%h", act, e); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_pass_through();
    test_forward_priority();
    test_load_use();
    test_flush_hazard();
    test_writethrough();
    test_reset_mid_stall();
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
